// File: rtl/sequencer_pkg.sv
// Shared constants for the phase sequencer: opcodes, per-opcode select codes
// and the phase-machine state encoding.
package sequencer_pkg;

  localparam logic [7:0] OP_PUSH_EBP    = 8'h55;
  localparam logic [7:0] OP_POP_EBP     = 8'h5D;
  localparam logic [7:0] OP_MOV_EBP_ESP = 8'h89;
  localparam logic [7:0] OP_MOV_EAX_IMM = 8'hB8;
  localparam logic [7:0] OP_CALL        = 8'hE8;
  localparam logic [7:0] OP_RET         = 8'hC3;
  localparam logic [7:0] OP_NOP         = 8'h90;
  localparam logic [7:0] OP_HLT         = 8'hF4;

  // Register-select codes presented during phases 3, 5 and 7.
  typedef struct packed {
    logic [3:0] sel1;
    logic [3:0] sel2;
    logic [3:0] sel3;
  } sel_codes_t;

  localparam sel_codes_t SEL_PUSH_EBP    = {4'd5, 4'd2, 4'd1};
  localparam sel_codes_t SEL_POP_EBP     = {4'd4, 4'd2, 4'd1};
  localparam sel_codes_t SEL_MOV_EBP_ESP = {4'd2, 4'd0, 4'd0};
  localparam sel_codes_t SEL_MOV_EAX_IMM = {4'd3, 4'd0, 4'd0};
  localparam sel_codes_t SEL_CALL        = {4'd1, 4'd3, 4'd2};
  localparam sel_codes_t SEL_RET         = {4'd4, 4'd5, 4'd2};
  localparam sel_codes_t SEL_NONE        = {4'd0, 4'd0, 4'd0};

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_S1   = 4'd1;
  localparam logic [3:0] ST_S2   = 4'd2;
  localparam logic [3:0] ST_S3   = 4'd3;
  localparam logic [3:0] ST_S4   = 4'd4;
  localparam logic [3:0] ST_S5   = 4'd5;
  localparam logic [3:0] ST_S6   = 4'd6;
  localparam logic [3:0] ST_S7   = 4'd7;
  localparam logic [3:0] ST_S8   = 4'd8;
  localparam logic [3:0] ST_HALT = 4'd9;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decoder: select codes plus halt/illegal flags.
// Shared with the pipelined fetch, so it holds no state.
module opcode_decoder
  import sequencer_pkg::*;
(
  input  logic [7:0] opcode,
  output sel_codes_t codes,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    codes      = SEL_NONE;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_PUSH_EBP:    codes = SEL_PUSH_EBP;
      OP_POP_EBP:     codes = SEL_POP_EBP;
      OP_MOV_EBP_ESP: codes = SEL_MOV_EBP_ESP;
      OP_MOV_EAX_IMM: codes = SEL_MOV_EAX_IMM;
      OP_CALL:        codes = SEL_CALL;
      OP_RET:         codes = SEL_RET;
      OP_NOP:         codes = SEL_NONE;
      OP_HLT:         is_halt = 1'b1;
      default:        is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/phase_sequencer.sv
// Eight-phase instruction sequencer driving phase strobes and register selects.
// Optional PHASE_SKIP_EN: skip phases 3/5/7 whose select code is zero.
module phase_sequencer
  import sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [7:0]  instr_opcode,
  output logic        instr_ready,
  input  logic        mem_wait,
  output logic        clock_3,
  output logic        clock_5,
  output logic        clock_7,
  output logic [3:0]  select_1,
  output logic [3:0]  select_2,
  output logic [3:0]  select_3,
  output logic        done,
  output logic        illegal,
  output logic        halted,
  output logic [15:0] retired
);

`ifdef PHASE_SKIP_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  logic [3:0]  state_q, state_d;
  sel_codes_t  sel_q, sel_d;
  logic        halt_pend_q, halt_pend_d;
  logic        clk3_q, clk3_d, clk5_q, clk5_d, clk7_q, clk7_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        halted_q, halted_d;
  logic [15:0] retired_q, retired_d;

  sel_codes_t  dec_codes;
  logic        dec_halt, dec_illegal;
  logic        accept, in_instr_d;

  opcode_decoder u_decoder (
    .opcode     (instr_opcode),
    .codes      (dec_codes),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;

  // mem_wait is honoured only in S4/S6, and the hold wins over any skip.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_S1;
      ST_S1:   state_d = ST_S2;
      ST_S2:   state_d = (SKIP_EN && sel_q.sel1 == 4'd0) ? ST_S4 : ST_S3;
      ST_S3:   state_d = ST_S4;
      ST_S4:   if (!mem_wait) state_d = (SKIP_EN && sel_q.sel2 == 4'd0) ? ST_S6 : ST_S5;
      ST_S5:   state_d = ST_S6;
      ST_S6:   if (!mem_wait) state_d = (SKIP_EN && sel_q.sel3 == 4'd0) ? ST_S8 : ST_S7;
      ST_S7:   state_d = ST_S8;
      ST_S8:   state_d = halt_pend_q ? ST_HALT : ST_IDLE;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from the next state so the registered versions line
  // up exactly with the state they describe.
  always_comb begin
    in_instr_d  = (state_d >= ST_S1) && (state_d <= ST_S8);
    sel_d       = accept ? dec_codes : (in_instr_d ? sel_q : SEL_NONE);
    halt_pend_d = accept ? dec_halt : halt_pend_q;
    clk3_d      = (state_d == ST_S3) && (sel_q.sel1 != 4'd0);
    clk5_d      = (state_d == ST_S5) && (sel_q.sel2 != 4'd0);
    clk7_d      = (state_d == ST_S7) && (sel_q.sel3 != 4'd0);
    done_d      = (state_d == ST_S8);
    retired_d   = retired_q + {15'd0, done_d};
    illegal_d   = illegal_q | (accept & dec_illegal);
    halted_d    = (state_d == ST_HALT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_NONE;
      halt_pend_q <= 1'b0;
      clk3_q      <= 1'b0;
      clk5_q      <= 1'b0;
      clk7_q      <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      sel_q       <= sel_d;
      halt_pend_q <= halt_pend_d;
      clk3_q      <= clk3_d;
      clk5_q      <= clk5_d;
      clk7_q      <= clk7_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
    end
  end

  assign clock_3  = clk3_q;
  assign clock_5  = clk5_q;
  assign clock_7  = clk7_q;
  assign select_1 = sel_q.sel1;
  assign select_2 = sel_q.sel2;
  assign select_3 = sel_q.sel3;
  assign done     = done_q;
  assign illegal  = illegal_q;
  assign halted   = halted_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed, table-driven bench for phase_sequencer, with hand-written
// sequences for halt, mid-instruction reset and stalls.
module tb_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [7:0]  instr_opcode;
  logic        instr_ready;
  logic        mem_wait;
  logic        clock_3, clock_5, clock_7;
  logic [3:0]  select_1, select_2, select_3;
  logic        done, illegal, halted;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;

`ifdef PHASE_SKIP_EN
  bit skip_en = 1'b1;
`else
  bit skip_en = 1'b0;
`endif

  logic        model_ill;
  logic [15:0] model_ret;

  typedef struct {
    logic [7:0] op;
    logic [3:0] s1, s2, s3;
    bit         ill;
    bit         halt;
    bit         hold;
    bit         noise;
    int         w4;
    int         w6;
  } vec_t;

  vec_t tbl [10];

  always #5 clock = ~clock;

  phase_sequencer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .instr_valid  (instr_valid),
    .instr_opcode (instr_opcode),
    .instr_ready  (instr_ready),
    .mem_wait     (mem_wait),
    .clock_3      (clock_3),
    .clock_5      (clock_5),
    .clock_7      (clock_7),
    .select_1     (select_1),
    .select_2     (select_2),
    .select_3     (select_3),
    .done         (done),
    .illegal      (illegal),
    .halted       (halted),
    .retired      (retired)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one opcode at a negedge in IDLE and check every cycle S1..S8.
  task automatic run_instr(input vec_t v);
    int ph[$];
    int p, nxt;
    string tag;
    ph.push_back(1);
    ph.push_back(2);
    if (!skip_en || v.s1 != 4'd0) ph.push_back(3);
    repeat (v.w4 + 1) ph.push_back(4);
    if (!skip_en || v.s2 != 4'd0) ph.push_back(5);
    repeat (v.w6 + 1) ph.push_back(6);
    if (!skip_en || v.s3 != 4'd0) ph.push_back(7);
    ph.push_back(8);

    check($sformatf("op%02h ready_idle", v.op), {31'd0, instr_ready}, 32'd1);
    instr_valid  = 1'b1;
    instr_opcode = v.op;
    mem_wait     = v.noise;
    @(negedge clock);
    instr_valid = v.hold;
    if (v.ill) model_ill = 1'b1;

    for (int c = 0; c < ph.size(); c++) begin
      p   = ph[c];
      tag = $sformatf("op%02h c%0d ph%0d", v.op, c + 1, p);
      if (p == 8) model_ret = model_ret + 16'd1;
      check({tag, " clock_3"}, {31'd0, clock_3}, {31'd0, (p == 3 && v.s1 != 4'd0)});
      check({tag, " clock_5"}, {31'd0, clock_5}, {31'd0, (p == 5 && v.s2 != 4'd0)});
      check({tag, " clock_7"}, {31'd0, clock_7}, {31'd0, (p == 7 && v.s3 != 4'd0)});
      check({tag, " select_1"}, {28'd0, select_1}, {28'd0, v.s1});
      check({tag, " select_2"}, {28'd0, select_2}, {28'd0, v.s2});
      check({tag, " select_3"}, {28'd0, select_3}, {28'd0, v.s3});
      check({tag, " done"}, {31'd0, done}, {31'd0, (p == 8)});
      check({tag, " ready"}, {31'd0, instr_ready}, 32'd0);
      check({tag, " illegal"}, {31'd0, illegal}, {31'd0, model_ill});
      if (p == 8) check({tag, " retired"}, {16'd0, retired}, {16'd0, model_ret});
      nxt = (c + 1 < ph.size()) ? ph[c + 1] : 0;
      mem_wait = ((p == 4 || p == 6) && nxt == p) ||
                 (v.noise && (p == 1 || p == 2 || p == 3 || p == 5 || p == 7 || p == 8));
      @(negedge clock);
    end
    mem_wait = 1'b0;

    tag = $sformatf("op%02h after", v.op);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " select_1"}, {28'd0, select_1}, 32'd0);
    check({tag, " select_2"}, {28'd0, select_2}, 32'd0);
    check({tag, " select_3"}, {28'd0, select_3}, 32'd0);
    check({tag, " ready"}, {31'd0, instr_ready}, {31'd0, !v.halt});
    check({tag, " halted"}, {31'd0, halted}, {31'd0, v.halt});
    check({tag, " retired"}, {16'd0, retired}, {16'd0, model_ret});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " clock_3"}, {31'd0, clock_3}, 32'd0);
    check({tag, " clock_5"}, {31'd0, clock_5}, 32'd0);
    check({tag, " clock_7"}, {31'd0, clock_7}, 32'd0);
    check({tag, " select_1"}, {28'd0, select_1}, 32'd0);
    check({tag, " select_2"}, {28'd0, select_2}, 32'd0);
    check({tag, " select_3"}, {28'd0, select_3}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, " halted"}, {31'd0, halted}, 32'd0);
    check({tag, " retired"}, {16'd0, retired}, 32'd0);
  endtask

  initial begin
    //          op     s1    s2    s3    ill halt hold noise w4 w6
    tbl[0] = '{8'h55, 4'd5, 4'd2, 4'd1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{8'h5D, 4'd4, 4'd2, 4'd1, 0, 0, 0, 1, 0, 1};
    tbl[2] = '{8'h89, 4'd2, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{8'hB8, 4'd3, 4'd0, 4'd0, 0, 0, 0, 0, 0, 2};
    tbl[4] = '{8'hE8, 4'd1, 4'd3, 4'd2, 0, 0, 0, 1, 0, 0};
    tbl[5] = '{8'hC3, 4'd4, 4'd5, 4'd2, 0, 0, 0, 1, 3, 0};
    tbl[6] = '{8'h90, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0};
    tbl[7] = '{8'h00, 4'd0, 4'd0, 4'd0, 1, 0, 0, 0, 0, 0};
    tbl[8] = '{8'h55, 4'd5, 4'd2, 4'd1, 0, 0, 1, 0, 1, 0};
    tbl[9] = '{8'h90, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0};

    reset_n      = 1'b0;
    instr_valid  = 1'b0;
    instr_opcode = 8'h00;
    mem_wait     = 1'b0;
    model_ill    = 1'b0;
    model_ret    = 16'd0;

    #1 check_all_zero("in_reset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_reset ready", {31'd0, instr_ready}, 32'd1);
    check_all_zero("post_reset");

    // Held valid on tbl[8] must not be re-accepted until IDLE; drop it after.
    for (int i = 0; i < 10; i++) begin
      run_instr(tbl[i]);
      instr_valid = 1'b0;
    end

    // Reset in S5 of call: outputs clear asynchronously.
    instr_valid  = 1'b1;
    instr_opcode = 8'hE8;
    @(negedge clock);
    instr_valid = 1'b0;
    repeat (4) @(negedge clock);
    check("call_s5 clock_5", {31'd0, clock_5}, 32'd1);
    check("call_s5 select_2", {28'd0, select_2}, 32'd3);
    #1 reset_n = 1'b0;
    #1 check_all_zero("mid_reset");
    check("mid_reset ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clock);
    reset_n   = 1'b1;
    model_ill = 1'b0;
    model_ret = 16'd0;
    @(negedge clock);
    run_instr(tbl[6]);

    // hlt with instr_valid held high afterwards.
    run_instr('{8'hF4, 4'd0, 4'd0, 4'd0, 0, 1, 1, 0, 0, 0});
    instr_opcode = 8'h55;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      check($sformatf("halt c%0d halted", i), {31'd0, halted}, 32'd1);
      check($sformatf("halt c%0d ready", i), {31'd0, instr_ready}, 32'd0);
      check($sformatf("halt c%0d clock_3", i), {31'd0, clock_3}, 32'd0);
    end
    check("halt retired", {16'd0, retired}, {16'd0, model_ret});
    instr_valid = 1'b0;
    reset_n     = 1'b0;
    #1 check("halt_reset halted", {31'd0, halted}, 32'd0);
    check("halt_reset ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clock);
    reset_n   = 1'b1;
    model_ill = 1'b0;
    model_ret = 16'd0;
    @(negedge clock);
    run_instr(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Control unit that drives the phase strobes and per-phase register-select codes consumed by the register-output selector. It accepts one opcode at a time from instruction fetch and steps a fixed eight-state phase machine. The machine pulses the phase-3, phase-5 and phase-7 strobes. During each pulse it presents the select code that routes the right register (eip/ebp/esp/eax/ebx/stack) onto the shared 32-bit register bus. It sits between fetch and the selector/register file and also counts retired instructions.

## Interface
- No parameters; opcode width is fixed at 8 bits, select codes at 4 bits.
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  fetch presents an opcode
- instr_opcode  in  8  opcode byte, sampled when instr_valid & instr_ready
- instr_ready  out  1  sequencer can accept an opcode
- mem_wait  in  1  stack/memory not ready; holds the machine in S4 or S6
- clock_3 / clock_5 / clock_7  out  1 each  phase strobes to the selector
- select_1 / select_2 / select_3  out  4 each  select codes for phases 3/5/7
- done  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  sticky; set on an undecoded opcode
- halted  out  1  sticky; set by HLT
- retired  out  16  retired-instruction count

## Operation
- States: IDLE, S1–S8, HALT.
- IDLE: instr_ready=1. On valid&ready, latch the decoded select codes and go to S1.
- Decode, as select_1/select_2/select_3:
  - 0x55 push ebp: 5/2/1
  - 0x5D pop ebp: 4/2/1
  - 0x89 mov ebp,esp: 2/0/0
  - 0xB8 mov eax,imm: 3/0/0
  - 0xE8 call: 1/3/2
  - 0xC3 ret: 4/5/2
  - 0x90 nop: 0/0/0
  - 0xF4 hlt: 0/0/0, then HALT
  - Any other opcode: executes as nop and sets illegal.
- Strobes:
  - clock_3 is high only in S3, clock_5 only in S5, clock_7 only in S7.
  - A strobe is suppressed when its select code is 0.
- Select outputs:
  - Hold the latched codes from S1 through S8.
  - Are 0 in IDLE and HALT.
- Stall: mem_wait=1 in S4 or S6 holds the state. It is ignored in every other state, so a strobe is never stretched.
- Completion:
  - S8 pulses done and increments retired (wraps 0xFFFF→0x0000).
  - S8 then returns to IDLE, or goes to HALT if the opcode was 0xF4.
- HALT: instr_ready=0, halted=1. Only reset_n leaves HALT.
- Reset (any time, including mid-instruction): state=IDLE. All strobes, selects, done, illegal, halted and retired are 0. instr_ready=1 from the first edge after release.

## Timing
- All outputs are registered except instr_ready, which is decoded from state.
- Accept edge → S1 on the next cycle. Full instruction = 8 cycles (S1–S8) with no stall.
- Throughput: one instruction per 9 cycles, because acceptance happens in IDLE only.
- Each mem_wait cycle in S4/S6 adds exactly one cycle of latency.
- instr_valid while not in IDLE: the opcode is not accepted. Fetch must hold it.

## Configuration
- PHASE_SKIP_EN defined:
  - A phase whose select code is 0 is skipped: S2→S4 if select_1=0, S4→S6 if select_2=0, S6→S8 if select_3=0.
  - mov ebp,esp takes 6 cycles; nop takes 5 (S1,S2,S4,S6,S8).
  - The mem_wait hold in S4/S6 applies before any skip is taken.
- PHASE_SKIP_EN undefined: every instruction visits all of S1–S8, always 8 cycles.

## Structure
- Shared package sequencer_pkg holds:
  - Opcode constants: OP_PUSH_EBP, OP_POP_EBP, OP_MOV_EBP_ESP, OP_MOV_EAX_IMM, OP_CALL, OP_RET, OP_NOP, OP_HLT.
  - Select-code constants for each phase.
  - The state encoding.
- Sub-module opcode_decoder: purely combinational. Maps opcode to the three select codes plus is_halt and is_illegal flags. It is reused by the future pipelined fetch.

## Test plan
- Reset then push ebp (0x55): accept cycle, then clock_3 in cycle 3 with select_1=5, clock_5 in cycle 5 with select_2=2, clock_7 in cycle 7 with select_3=1. done in cycle 8; retired=1.
- ret (0xC3) with mem_wait high for 3 cycles in S4: clock_5 delayed by exactly 3 cycles with select_2=5. clock_3/clock_7 widths stay 1 cycle. Total 11 cycles.
- Opcode 0x00: no strobes, illegal=1 and stays set. done after 8 cycles; next opcode accepted normally.
- hlt (0xF4), then instr_valid held high: halted=1 and instr_ready=0 indefinitely. Pulsing reset_n low → IDLE, halted=0.
- reset_n asserted during S5 of call: clock_5, select_* and done go to 0 immediately and retired=0. The next accepted nop completes cleanly.
- PHASE_SKIP_EN build, nop: done 5 cycles after accept, no strobes. Without the macro: 8 cycles.
